// File: rtl/csi2_pkg.sv
// csi2_pkg: constants and types shared by the CSI-2 RX and TX blocks.
//   - Data-type codes for the short packets and RGB888 long packets.
//   - Parity masks for the 6-bit header ECC (bit n of a mask = header bit n).
//   - CRC-16 polynomial and seed.
//   - RX depacketizer FSM states.
package csi2_pkg;

   // Data types (6-bit DT field of the DI byte)
   localparam logic [5:0] DtFs      = 6'h00;
   localparam logic [5:0] DtFe      = 6'h01;
   localparam logic [5:0] DtLs      = 6'h02;
   localparam logic [5:0] DtLe      = 6'h03;
   localparam logic [5:0] DtRgb888  = 6'h24;
   // DTs below this value are short packets
   localparam logic [5:0] DtLongMin = 6'h10;

   // ECC parity masks over header bits {WC[15:8], WC[7:0], DI}
   localparam logic [23:0] EccMaskP0 = 24'hF12CB7;
   localparam logic [23:0] EccMaskP1 = 24'hF2555B;
   localparam logic [23:0] EccMaskP2 = 24'h749A6D;
   localparam logic [23:0] EccMaskP3 = 24'hB8E38E;
   localparam logic [23:0] EccMaskP4 = 24'hDF03F0;
   localparam logic [23:0] EccMaskP5 = 24'hEFFC00;

   // CRC-16 x^16+x^12+x^5+1; data enters LSB first, so the shift register runs
   // right-shifting with the bit-reversed polynomial.
   localparam logic [15:0] CrcPoly     = 16'h1021;
   localparam logic [15:0] CrcPolyRefl = 16'h8408;
   localparam logic [15:0] CrcInit     = 16'hFFFF;

   typedef enum logic [2:0] {
      StIdle,
      StHdr,
      StPay,
      StCrc,
      StSkip,
      StDrain
   } csi2_rx_state_e;

endpackage

// File: rtl/csi2_crc16_w16.sv
// csi2_crc16_w16: combinational next-state of the CSI-2 payload CRC-16 for one
// 16-bit word. The CRC register lives in the parent.
//   crc_i  : current CRC value
//   data_i : payload word; bits [7:0] are the earlier byte, each byte LSB first
//   crc_o  : CRC after absorbing all 16 bits of data_i
module csi2_crc16_w16
   import csi2_pkg::*;
(
   input  logic [15:0] crc_i,
   input  logic [15:0] data_i,
   output logic [15:0] crc_o
);

   logic [15:0] c;
   logic        fb;

   // Bit 0 of data_i is the first bit on the wire, bit 15 the last.
   always_comb begin
      c  = crc_i;
      fb = 1'b0;
      for (int i = 0; i < 16; i++) begin
         fb = c[0] ^ data_i[i];
         c  = (c >> 1) ^ ({16{fb}} & CrcPolyRefl);
      end
      crc_o = c;
   end

endmodule

// File: rtl/csi2_rx_depacketizer.sv
// csi2_rx_depacketizer: decodes one CSI-2 packet per 2-lane HS burst and
// rebuilds a parallel RGB888 pixel interface.
//   byte_clk_i   : byte clock
//   reset_n_i    : synchronous active-low reset
//   byte_data_i  : merged lane bytes, [7:0] = lane0 (earlier), [15:8] = lane1
//   byte_valid_i : high for the whole burst, one word per cycle
//   fv_o/lv_o    : frame / line valid
//   dvalid_o     : pixel strobe, pixdata_o [7:0] = first payload byte of pixel
//   ecc_err_o    : pulse, header ECC mismatch
//   crc_err_o    : pulse, payload CRC mismatch
//   pkt_err_o    : pulse, truncated burst or illegal pixel word count
module csi2_rx_depacketizer
   import csi2_pkg::*;
#(
   parameter logic [1:0]  VC     = 2'd0,
   parameter logic [7:0]  DT_PIX = 8'h24,
   parameter logic [15:0] MAX_WC = 16'd11520
) (
   input  logic        byte_clk_i,
   input  logic        reset_n_i,
   input  logic [15:0] byte_data_i,
   input  logic        byte_valid_i,
   output logic        fv_o,
   output logic        lv_o,
   output logic        dvalid_o,
   output logic [23:0] pixdata_o,
   output logic        ecc_err_o,
   output logic        crc_err_o,
   output logic        pkt_err_o
);

   function automatic logic [5:0] ecc_calc(input logic [23:0] d);
      return {^(d & EccMaskP5), ^(d & EccMaskP4), ^(d & EccMaskP3),
              ^(d & EccMaskP2), ^(d & EccMaskP1), ^(d & EccMaskP0)};
   endfunction

   csi2_rx_state_e state_q;
   logic [7:0]     di_q;
   logic [7:0]     wc_lo_q;
   logic [14:0]    wc_half_q;
   logic [14:0]    word_cnt_q;
   logic [1:0]     phase_q;
   logic [15:0]    crc_q;
   logic [15:0]    crc_next;
   logic [15:0]    pix_lo_q;   // b1,b0 held until the pixel A word arrives
   logic [7:0]     b3_q;       // b3 held until the pixel B word arrives
   logic           valid_prev_q;
   logic           fv_q, lv_q, dvalid_q, ecc_err_q, crc_err_q, pkt_err_q;
   logic [23:0]    pix_q;

   // Header decode, valid while word1 is on byte_data_i in StHdr
   logic [15:0] wc;
   logic [5:0]  dt;
   logic        ecc_ok;
   logic        vc_ok;
   logic        wc_bad;

   assign wc     = {byte_data_i[7:0], wc_lo_q};
   assign dt     = di_q[5:0];
   assign ecc_ok = (ecc_calc({byte_data_i[7:0], wc_lo_q, di_q}) == byte_data_i[13:8]);
   assign vc_ok  = (di_q[7:6] == VC);
   assign wc_bad = (wc == 16'd0) || (wc > MAX_WC) || ((wc % 16'd6) != 16'd0);

   csi2_crc16_w16 u_crc (
      .crc_i  (crc_q),
      .data_i (byte_data_i),
      .crc_o  (crc_next)
   );

   always_ff @(posedge byte_clk_i) begin
      if (!reset_n_i) begin
         state_q      <= StIdle;
         di_q         <= 8'd0;
         wc_lo_q      <= 8'd0;
         wc_half_q    <= 15'd0;
         word_cnt_q   <= 15'd0;
         phase_q      <= 2'd0;
         crc_q        <= CrcInit;
         pix_lo_q     <= 16'd0;
         b3_q         <= 8'd0;
         valid_prev_q <= 1'b0;
         fv_q         <= 1'b0;
         lv_q         <= 1'b0;
         dvalid_q     <= 1'b0;
         pix_q        <= 24'd0;
         ecc_err_q    <= 1'b0;
         crc_err_q    <= 1'b0;
         pkt_err_q    <= 1'b0;
      end else begin
         valid_prev_q <= byte_valid_i;
         dvalid_q     <= 1'b0;
         ecc_err_q    <= 1'b0;
         crc_err_q    <= 1'b0;
         pkt_err_q    <= 1'b0;

         // Burst ended before the packet did; fv is left as is.
         if (!byte_valid_i && (state_q inside {StHdr, StPay, StCrc, StSkip})) begin
            pkt_err_q <= 1'b1;
            lv_q      <= 1'b0;
            state_q   <= StIdle;
         end else begin
            unique case (state_q)
               StIdle: begin
                  if (byte_valid_i && !valid_prev_q) begin
                     di_q    <= byte_data_i[7:0];
                     wc_lo_q <= byte_data_i[15:8];
                     state_q <= StHdr;
                  end
               end
               StHdr: begin
                  state_q <= StDrain;
                  if (!ecc_ok) begin
                     ecc_err_q <= 1'b1;
                  end else if (!vc_ok) begin
                     // silently dropped
                  end else if (dt < DtLongMin) begin
                     if (dt == DtFs) fv_q <= 1'b1;
                     else if (dt == DtFe) fv_q <= 1'b0;
                  end else if (dt == DT_PIX[5:0]) begin
                     if (wc_bad) begin
                        pkt_err_q <= 1'b1;
                     end else begin
                        wc_half_q  <= wc[15:1];
                        word_cnt_q <= 15'd0;
                        phase_q    <= 2'd0;
                        crc_q      <= CrcInit;
                        state_q    <= StPay;
                     end
                  end else begin
                     wc_half_q  <= wc[15:1];
                     word_cnt_q <= 15'd0;
                     state_q    <= StSkip;
                  end
               end
               StPay: begin
                  crc_q      <= crc_next;
                  word_cnt_q <= word_cnt_q + 15'd1;
                  case (phase_q)
                     2'd0: begin
                        pix_lo_q <= byte_data_i;
                        phase_q  <= 2'd1;
                     end
                     2'd1: begin
                        pix_q    <= {byte_data_i[7:0], pix_lo_q};
                        b3_q     <= byte_data_i[15:8];
                        dvalid_q <= 1'b1;
                        lv_q     <= 1'b1;
                        phase_q  <= 2'd2;
                     end
                     default: begin
                        pix_q    <= {byte_data_i, b3_q};
                        dvalid_q <= 1'b1;
                        lv_q     <= 1'b1;
                        phase_q  <= 2'd0;
                     end
                  endcase
                  if (word_cnt_q == wc_half_q - 15'd1) state_q <= StCrc;
               end
               StCrc: begin
                  crc_err_q <= (byte_data_i != crc_q);
                  lv_q      <= 1'b0;
                  state_q   <= StDrain;
               end
               StSkip: begin
                  // payload words plus the CRC word
                  word_cnt_q <= word_cnt_q + 15'd1;
                  if (word_cnt_q == wc_half_q) state_q <= StDrain;
               end
               StDrain: begin
                  if (!byte_valid_i) state_q <= StIdle;
               end
               default: state_q <= StIdle;
            endcase
         end
      end
   end

   assign fv_o      = fv_q;
   assign lv_o      = lv_q;
   assign dvalid_o  = dvalid_q;
   assign pixdata_o = pix_q;
   assign ecc_err_o = ecc_err_q;
   assign crc_err_o = crc_err_q;
   assign pkt_err_o = pkt_err_q;

endmodule

// File: tb/tb_csi2_rx_depacketizer.sv
// Directed bench for csi2_rx_depacketizer. Each burst is driven word by word;
// outputs are logged per cycle, where log index c is cycle H+c (word0 at H).
module tb_csi2_rx_depacketizer;
   import csi2_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [15:0] data = 16'd0;
   logic        valid = 1'b0;
   logic        fv, lv, dvalid, ecc_err, crc_err, pkt_err;
   logic [23:0] pix;

   int n_cmp = 0;
   int n_err = 0;

   logic [15:0] wq [0:15];
   int          nw;
   logic        lg_fv [0:31];
   logic        lg_lv [0:31];
   logic        lg_dv [0:31];
   logic        lg_ecc [0:31];
   logic        lg_crc [0:31];
   logic        lg_pkt [0:31];
   logic [23:0] lg_pix [0:31];

   csi2_rx_depacketizer dut (
      .byte_clk_i   (clk),
      .reset_n_i    (rst_n),
      .byte_data_i  (data),
      .byte_valid_i (valid),
      .fv_o         (fv),
      .lv_o         (lv),
      .dvalid_o     (dvalid),
      .pixdata_o    (pix),
      .ecc_err_o    (ecc_err),
      .crc_err_o    (crc_err),
      .pkt_err_o    (pkt_err)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic log_cycle(input int c);
      lg_fv[c]  = fv;
      lg_lv[c]  = lv;
      lg_dv[c]  = dvalid;
      lg_ecc[c] = ecc_err;
      lg_crc[c] = crc_err;
      lg_pkt[c] = pkt_err;
      lg_pix[c] = pix;
   endtask

   // Drives wq[0..nw-1] back to back, then four idle cycles.
   task automatic run_burst();
      for (int i = 0; i < nw; i++) begin
         data  = wq[i];
         valid = 1'b1;
         step();
         log_cycle(i + 1);
      end
      valid = 1'b0;
      data  = 16'd0;
      for (int i = nw; i < nw + 4; i++) begin
         step();
         log_cycle(i + 1);
      end
   endtask

   // Reference CRC: byte-serial, reflected form, bytes b0 first.
   function automatic logic [15:0] crc_model(input int first, input int count);
      logic [15:0] c;
      logic [7:0]  b;
      c = 16'hFFFF;
      for (int w = first; w < first + count; w++) begin
         for (int k = 0; k < 2; k++) begin
            b = wq[w][8*k +: 8];
            c = c ^ {8'h00, b};
            for (int j = 0; j < 8; j++) c = c[0] ? ((c >> 1) ^ 16'h8408) : (c >> 1);
         end
      end
      return c;
   endfunction

   // RGB888, WC=12, payload bytes 0x01..0x0C, CRC word xored with crc_xor.
   task automatic load_pix_packet(input logic [15:0] crc_xor);
      wq[0] = 16'h0C24;
      wq[1] = 16'h1E00;
      wq[2] = 16'h0201;
      wq[3] = 16'h0403;
      wq[4] = 16'h0605;
      wq[5] = 16'h0807;
      wq[6] = 16'h0A09;
      wq[7] = 16'h0C0B;
      wq[8] = crc_model(2, 6) ^ crc_xor;
      nw    = 9;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      valid = 1'b1;
      data  = 16'hFFFF;
      repeat (3) step();
      n_cmp++;
      if ({fv, lv, dvalid, ecc_err, crc_err, pkt_err, pix} !== 30'd0) begin
         n_err++;
         $display("FAIL reset_outputs: got %b_%h want 000000_000000",
                  {fv, lv, dvalid, ecc_err, crc_err, pkt_err}, pix);
      end
      valid = 1'b0;
      step();
      rst_n = 1'b1;
      repeat (2) step();
      n_cmp++;
      if (dut.state_q !== StIdle) begin
         n_err++;
         $display("FAIL reset_state: got %0d want %0d", dut.state_q, StIdle);
      end
   endtask

   task automatic test_fs_fe();
      wq[0] = 16'h0000; wq[1] = 16'h0000; nw = 2;
      run_burst();
      n_cmp++;
      if (lg_fv[1] !== 1'b0 || lg_fv[2] !== 1'b1) begin
         n_err++;
         $display("FAIL fs_fv: got H+1=%b H+2=%b want 0 1", lg_fv[1], lg_fv[2]);
      end
      n_cmp++;
      if (lg_ecc[2] !== 1'b0 || lg_pkt[2] !== 1'b0) begin
         n_err++;
         $display("FAIL fs_err: got ecc=%b pkt=%b want 0 0", lg_ecc[2], lg_pkt[2]);
      end
      wq[0] = 16'h0001; wq[1] = 16'h0700; nw = 2;
      run_burst();
      n_cmp++;
      if (lg_fv[1] !== 1'b1 || lg_fv[2] !== 1'b0) begin
         n_err++;
         $display("FAIL fe_fv: got H+1=%b H+2=%b want 1 0", lg_fv[1], lg_fv[2]);
      end
   endtask

   task automatic test_ecc_err();
      wq[0] = 16'h0000; wq[1] = 16'h0100; nw = 2;
      run_burst();
      n_cmp++;
      if (lg_ecc[2] !== 1'b1 || lg_ecc[3] !== 1'b0) begin
         n_err++;
         $display("FAIL ecc_pulse: got H+2=%b H+3=%b want 1 0", lg_ecc[2], lg_ecc[3]);
      end
      n_cmp++;
      if (lg_fv[2] !== 1'b0 || lg_fv[4] !== 1'b0) begin
         n_err++;
         $display("FAIL ecc_fv: got %b %b want 0 0", lg_fv[2], lg_fv[4]);
      end
   endtask

   task automatic check_pix_packet(input logic crc_bad);
      logic [23:0] exp_pix [4];
      int          exp_cyc [4];
      logic        e;
      exp_pix = '{24'h030201, 24'h060504, 24'h090807, 24'h0C0B0A};
      exp_cyc = '{4, 5, 7, 8};
      for (int c = 2; c <= 12; c++) begin
         e = (c == 4 || c == 5 || c == 7 || c == 8);
         n_cmp++;
         if (lg_dv[c] !== e) begin
            n_err++;
            $display("FAIL dvalid_H+%0d: got %b want %b", c, lg_dv[c], e);
         end
         e = (c >= 4 && c <= 8);
         n_cmp++;
         if (lg_lv[c] !== e) begin
            n_err++;
            $display("FAIL lv_H+%0d: got %b want %b", c, lg_lv[c], e);
         end
         e = crc_bad && (c == 9);
         n_cmp++;
         if (lg_crc[c] !== e || lg_pkt[c] !== 1'b0) begin
            n_err++;
            $display("FAIL crc_pkt_H+%0d: got crc=%b pkt=%b want %b 0", c, lg_crc[c],
                     lg_pkt[c], e);
         end
      end
      for (int i = 0; i < 4; i++) begin
         n_cmp++;
         if (lg_pix[exp_cyc[i]] !== exp_pix[i]) begin
            n_err++;
            $display("FAIL pixel%0d: got %h want %h", i, lg_pix[exp_cyc[i]], exp_pix[i]);
         end
      end
   endtask

   task automatic test_pixels();
      load_pix_packet(16'h0000);
      run_burst();
      check_pix_packet(1'b0);
   endtask

   task automatic test_crc_err();
      load_pix_packet(16'h0001);
      run_burst();
      check_pix_packet(1'b1);
   endtask

   task automatic test_truncation();
      load_pix_packet(16'h0000);
      nw = 6;
      run_burst();
      n_cmp++;
      if (lg_dv[4] !== 1'b1 || lg_dv[5] !== 1'b1 || lg_dv[6] !== 1'b0) begin
         n_err++;
         $display("FAIL trunc_dvalid: got %b%b%b want 110", lg_dv[4], lg_dv[5], lg_dv[6]);
      end
      n_cmp++;
      if (lg_pkt[6] !== 1'b0 || lg_pkt[7] !== 1'b1 || lg_pkt[8] !== 1'b0) begin
         n_err++;
         $display("FAIL trunc_pkt: got %b%b%b want 010", lg_pkt[6], lg_pkt[7], lg_pkt[8]);
      end
      n_cmp++;
      if (lg_lv[6] !== 1'b1 || lg_lv[7] !== 1'b0) begin
         n_err++;
         $display("FAIL trunc_lv: got %b%b want 10", lg_lv[6], lg_lv[7]);
      end
      n_cmp++;
      if (dut.state_q !== StIdle) begin
         n_err++;
         $display("FAIL trunc_state: got %0d want %0d", dut.state_q, StIdle);
      end
   endtask

   task automatic test_bad_wc();
      load_pix_packet(16'h0000);
      wq[0] = 16'h0A24;
      wq[1] = 16'h2100;
      nw    = 8;
      run_burst();
      n_cmp++;
      if (lg_pkt[2] !== 1'b1 || lg_pkt[3] !== 1'b0 || lg_ecc[2] !== 1'b0) begin
         n_err++;
         $display("FAIL badwc_pkt: got pkt=%b%b ecc=%b want 10 0", lg_pkt[2], lg_pkt[3],
                  lg_ecc[2]);
      end
      for (int c = 1; c <= 12; c++) begin
         n_cmp++;
         if (lg_dv[c] !== 1'b0 || lg_lv[c] !== 1'b0) begin
            n_err++;
            $display("FAIL badwc_pix_H+%0d: got dv=%b lv=%b want 0 0", c, lg_dv[c], lg_lv[c]);
         end
      end
   endtask

   task automatic test_vc();
      wq[0] = 16'h0000; wq[1] = 16'h0000; nw = 2;
      run_burst();
      // FE on VC1 must not clear fv
      wq[0] = 16'h0041; wq[1] = 16'h1100; nw = 2;
      run_burst();
      n_cmp++;
      if (lg_fv[3] !== 1'b1 || lg_ecc[2] !== 1'b0) begin
         n_err++;
         $display("FAIL vc1_fe: got fv=%b ecc=%b want 1 0", lg_fv[3], lg_ecc[2]);
      end
      load_pix_packet(16'h0000);
      wq[0] = 16'h0C64;
      wq[1] = 16'h0800;
      run_burst();
      for (int c = 1; c <= 13; c++) begin
         n_cmp++;
         if ({lg_fv[c], lg_lv[c], lg_dv[c], lg_ecc[c], lg_crc[c], lg_pkt[c]} !== 6'b100000) begin
            n_err++;
            $display("FAIL vc1_pix_H+%0d: got %b want 100000", c,
                     {lg_fv[c], lg_lv[c], lg_dv[c], lg_ecc[c], lg_crc[c], lg_pkt[c]});
         end
      end
   endtask

   task automatic test_reset_midpacket();
      load_pix_packet(16'h0000);
      for (int i = 0; i < 5; i++) begin
         data  = wq[i];
         valid = 1'b1;
         step();
      end
      n_cmp++;
      if (lv !== 1'b1 || fv !== 1'b1) begin
         n_err++;
         $display("FAIL mid_pre: got lv=%b fv=%b want 1 1", lv, fv);
      end
      data  = wq[5];
      rst_n = 1'b0;
      step();
      n_cmp++;
      if ({fv, lv, dvalid, ecc_err, crc_err, pkt_err, pix} !== 30'd0) begin
         n_err++;
         $display("FAIL mid_reset: got %b_%h want 000000_000000",
                  {fv, lv, dvalid, ecc_err, crc_err, pkt_err}, pix);
      end
      n_cmp++;
      if (dut.state_q !== StIdle) begin
         n_err++;
         $display("FAIL mid_state: got %0d want %0d", dut.state_q, StIdle);
      end
      valid = 1'b0;
      rst_n = 1'b1;
      repeat (2) step();
   endtask

   initial begin
      test_reset();
      test_fs_fe();
      test_ecc_err();
      test_pixels();
      test_crc_err();
      test_truncation();
      test_bad_wc();
      test_vc();
      test_reset_midpacket();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
